spi_arb: RTL and testbench

SPI_ARB -- requirements
Module: spi_arb

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_arb_rr_pick.sv | 34 +++
 rtl/spi_arb.sv | 180 ++++++++++++++++++
 tb/tb_spi_arb.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM state encoding and default sizing for the SPI arbiter.
package spi_pkg;

    localparam int unsigned SPI_M   = 9;    // SPI word width
    localparam int unsigned SPI_N   = 4;    // number of requesters
    localparam int unsigned SPI_TMO = 255;  // watchdog limit in clk cycles

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        WAIT_LO = 3'd2,
        WAIT_HI = 3'd3,
        DONE    = 3'd4
    } spi_state_e;

    // Width of a requester index; a single requester still needs one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_arb_rr_pick.sv
// rr_pick: round-robin selector. The search starts at ptr and wraps; the
// first pending request wins. Purely combinational.
module rr_pick
    import spi_pkg::*;
#(
    parameter int unsigned N  = SPI_N,
    parameter int unsigned PW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  win,
    output logic [PW-1:0] idx
);

    logic          found;
    logic [PW-1:0] j;

    // Walk the requesters from ptr upward (modulo N) and take the first one set.
    always_comb begin
        win   = '0;
        idx   = '0;
        found = 1'b0;
        j     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            j = PW'((32'(ptr) + k) % N);
            if (!found && req[j]) begin
                found  = 1'b1;
                win[j] = 1'b1;
                idx    = j;
            end
        end
    end

endmodule

// File: rtl/spi_arb.sv
// spi_arb: N-way round-robin arbiter in front of a single SPI master.
// The winner's TX word is latched and handed to the master; the received
// word is returned with a one-cycle done pulse to the winner.
// Optional watchdog: define SPI_ARB_TIMEOUT_EN to abort a transfer that
// stalls for TMO cycles (err pulse instead of done).
module spi_arb
    import spi_pkg::*;
#(
    parameter int unsigned M   = SPI_M,
    parameter int unsigned N   = SPI_N,
    parameter int unsigned TMO = SPI_TMO
) (
    input  logic           clk,
    input  logic           clr,
    input  logic [N-1:0]   req,
    input  logic [N*M-1:0] tx_dat,
    output logic [N-1:0]   gnt,
    output logic [N-1:0]   done,
    output logic [M-1:0]   rx_dat,
    output logic           busy,
    output logic           err,
    output logic           spi_st,
    output logic [M-1:0]   spi_di,
    input  logic           spi_load,
    input  logic [M-1:0]   spi_do
);

    localparam int unsigned PW = idx_width(N);

    if (TMO < 1) begin : g_bad_tmo
        $error("spi_arb: TMO must be at least 1");
    end

    spi_state_e    state_q, state_d;
    logic [PW-1:0] ptr_q,   ptr_d;
    logic [PW-1:0] win_q,   win_d;
    logic [N-1:0]  gnt_q,   gnt_d;
    logic [N-1:0]  done_q,  done_d;
    logic [M-1:0]  rx_q,    rx_d;
    logic [M-1:0]  di_q,    di_d;

    logic [N-1:0]  pick_win;
    logic [PW-1:0] pick_idx;
    logic [M-1:0]  tx_w [N];
    logic          tmo_hit;

    rr_pick #(
        .N  (N),
        .PW (PW)
    ) u_pick (
        .req (req),
        .ptr (ptr_q),
        .win (pick_win),
        .idx (pick_idx)
    );

    for (genvar g = 0; g < N; g++) begin : g_unpack
        assign tx_w[g] = tx_dat[g*M +: M];
    end

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TMO + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    // cnt_q is 0 in the first WAIT_LO cycle, so TMO-1 marks the TMO-th wait cycle.
    assign tmo_hit = (cnt_q == CW'(TMO - 1));
    assign err     = err_q;

    // Watchdog counter and abort pulse register.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

    // Arbitration, handshake sequencing with the SPI master, and completion.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        rx_d    = rx_q;
        di_d    = di_q;
`ifdef SPI_ARB_TIMEOUT_EN
        err_d   = 1'b0;
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_d   = pick_win;
                    win_d   = pick_idx;
                    di_d    = tx_w[pick_idx];
                    state_d = START;
                end
            end
            START: begin
`ifdef SPI_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
                state_d = WAIT_LO;
            end
            WAIT_LO: begin
`ifdef SPI_ARB_TIMEOUT_EN
                cnt_d = cnt_q + CW'(1);
`endif
                // Real progress from the master takes priority over the watchdog.
                if (!spi_load) begin
                    state_d = WAIT_HI;
                end else if (tmo_hit) begin
`ifdef SPI_ARB_TIMEOUT_EN
                    err_d   = 1'b1;
`endif
                    state_d = DONE;
                end
            end
            WAIT_HI: begin
`ifdef SPI_ARB_TIMEOUT_EN
                cnt_d = cnt_q + CW'(1);
`endif
                if (spi_load) begin
                    rx_d    = spi_do;
                    done_d  = gnt_q;
                    state_d = DONE;
                end else if (tmo_hit) begin
`ifdef SPI_ARB_TIMEOUT_EN
                    err_d   = 1'b1;
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                gnt_d   = '0;
                ptr_d   = (win_q == PW'(N - 1)) ? '0 : win_q + PW'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            rx_q    <= '0;
            di_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            rx_q    <= rx_d;
            di_q    <= di_d;
        end
    end

    assign gnt    = gnt_q;
    assign done   = done_q;
    assign rx_dat = rx_q;
    assign spi_di = di_q;
    assign busy   = (state_q != IDLE);
    assign spi_st = (state_q == START);

endmodule

// File: tb/tb_spi_arb.sv
// tb_spi_arb: directed bench for spi_arb with a timestamp-based reference
// model and a loopback SPI master. Works with or without SPI_ARB_TIMEOUT_EN.
module tb_spi_arb;

    localparam int M   = 9;
    localparam int N   = 4;
    localparam int TMO = 16;

    logic           clk = 1'b0;
    logic           clr = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*M-1:0] tx_dat = '0;
    logic [N-1:0]   gnt, done;
    logic [M-1:0]   rx_dat, spi_di;
    logic           busy, err, spi_st;
    logic           spi_load = 1'b1;
    logic [M-1:0]   spi_do = '0;

    spi_arb #(.M(M), .N(N), .TMO(TMO)) dut (
        .clk(clk), .clr(clr), .req(req), .tx_dat(tx_dat),
        .gnt(gnt), .done(done), .rx_dat(rx_dat), .busy(busy), .err(err),
        .spi_st(spi_st), .spi_di(spi_di), .spi_load(spi_load), .spi_do(spi_do)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- reference model ----------------
    // A transaction is described by who owns it, when it started (START cycle),
    // and the cycle its result (done or err) is due.
    int           m_owner = -1;
    int           m_ptr = 0;
    int           m_tstart = -1;
    int           m_fin = -1;
    bit           m_lo = 0;
    bit           m_iserr = 0;
    logic [M-1:0] m_word = '0;
    logic [M-1:0] m_rx = '0;

    always @(posedge clk) begin : model
        int c;
        bit prog;
        c = cyc;
        cyc++;
        prog = 0;
        if (clr) begin
            m_owner = -1; m_ptr = 0; m_word = '0; m_rx = '0;
            m_fin = -1; m_iserr = 0; m_tstart = -1; m_lo = 0;
        end else if (m_owner < 0) begin
            if (req != '0) begin
                for (int k = 0; k < N; k++)
                    if (m_owner < 0 && req[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
                m_word = tx_dat[m_owner*M +: M];
                m_tstart = cyc; m_lo = 0; m_fin = -1; m_iserr = 0;
            end
        end else if (m_fin >= 0) begin
            m_ptr = (m_owner + 1) % N;
            m_owner = -1;
        end else if (c > m_tstart) begin
            if (!m_lo) begin
                if (!spi_load) begin m_lo = 1; prog = 1; end
            end else if (spi_load) begin
                m_fin = cyc; m_rx = spi_do; prog = 1;
            end
`ifdef SPI_ARB_TIMEOUT_EN
            if (!prog && (c - m_tstart) == TMO) begin m_fin = cyc; m_iserr = 1; end
`endif
        end
    end

    // ---------------- per-cycle compare + monitors ----------------
    int           st_cnt = 0;
    int           done_cnt = 0;
    logic [N-1:0] prev_gnt = '0;
    logic [N-1:0] gq[$];

    always @(negedge clk) begin : compare
        logic [N-1:0] eg, ed;
        logic         est, ebusy, eerr;
        logic [M-1:0] erx, edi;
        eg = '0; ed = '0; est = 0; ebusy = 0; eerr = 0; erx = '0; edi = '0;
        if (!clr) begin
            if (m_owner >= 0) begin
                eg[m_owner] = 1'b1;
                ebusy = 1'b1;
                est = (cyc == m_tstart);
                if (m_fin == cyc) begin
                    if (m_iserr) eerr = 1'b1;
                    else ed[m_owner] = 1'b1;
                end
            end
            erx = m_rx;
            edi = m_word;
        end
        chk("gnt", gnt, eg);
        chk("done", done, ed);
        chk("spi_st", spi_st, est);
        chk("busy", busy, ebusy);
        chk("err", err, eerr);
        chk("rx_dat", rx_dat, erx);
        chk("spi_di", spi_di, edi);
        if (spi_st === 1'b1) st_cnt++;
        if (done != '0) done_cnt++;
        if (gnt != '0 && prev_gnt == '0) gq.push_back(gnt);
        prev_gnt = gnt;
    end

    // ---------------- SPI master (loopback with optional XOR) ----------------
    bit           m_stuck = 0;
    int           m_len = 4;
    logic [M-1:0] m_mask = '0;

    initial begin : master
        logic [M-1:0] w;
        forever begin
            @(negedge clk);
            if (spi_st === 1'b1 && !m_stuck) begin
                w = spi_di;
                @(posedge clk); #1 spi_load = 1'b0;
                repeat (m_len) @(posedge clk);
                #1 spi_load = 1'b1;
                spi_do = w ^ m_mask;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic set_tx(input int i, input logic [M-1:0] w);
        tx_dat[i*M +: M] = w;
    endtask

    // sel: 0 gnt!=0, 1 done!=0, 2 spi_load==0, 3 spi_st, 4 err, 5 !busy
    task automatic wait_for(input string name, input int sel, input int limit);
        bit hit;
        hit = 0;
        for (int i = 0; i < limit && !hit; i++) begin
            @(negedge clk);
            case (sel)
                0: hit = (gnt != '0);
                1: hit = (done != '0);
                2: hit = (spi_load == 1'b0);
                3: hit = (spi_st == 1'b1);
                4: hit = (err == 1'b1);
                default: hit = (busy == 1'b0);
            endcase
        end
        if (!hit) begin
            n_total++;
            $display("FAIL %s: timed out after %0d cycles, want event", name, limit);
        end
    endtask

    initial begin : stim
        logic [N-1:0] exp_order [5];
        int t_st;
        exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rx", rx_dat, 0);
        chk("rst_di", spi_di, 0);
        tick(); clr = 1'b0;
        repeat (2) tick();

        // single requester, loopback
        set_tx(0, 9'h1A5); st_cnt = 0; m_mask = '0; m_len = 4;
        req = 4'b0001;
        wait_for("t1_gnt_wait", 0, 10);
        req = '0;
        chk("t1_gnt", gnt, 4'b0001);
        wait_for("t1_done_wait", 1, 100);
        chk("t1_done", done, 4'b0001);
        chk("t1_rx", rx_dat, 9'h1A5);
        chk("t1_di", spi_di, 9'h1A5);
        chk("t1_st_pulses", st_cnt, 1);
        wait_for("t1_idle", 5, 10);

        // all requesting from reset: order 0,1,2,3,0
        tick(); clr = 1'b1; tick(); clr = 1'b0; tick();
        set_tx(0, 9'h011); set_tx(1, 9'h022); set_tx(2, 9'h044); set_tx(3, 9'h088);
        m_mask = 9'h0FF; m_len = 1; gq.delete();
        req = 4'b1111;
        for (int i = 0; i < 200 && gq.size() < 5; i++) @(negedge clk);
        req = '0;
        chk("t2_grant_count", gq.size(), 5);
        wait_for("t2_done_wait", 1, 100);
        chk("t2_rx", rx_dat, 9'h0EE);
        wait_for("t2_idle", 5, 10);
        for (int i = 0; i < 5; i++)
            chk("t2_order", (i < gq.size()) ? gq[i] : '0, exp_order[i]);

        // request dropped right after grant
        m_mask = '0; m_len = 4; done_cnt = 0;
        set_tx(2, 9'h155);
        req = 4'b0100;
        wait_for("t3_gnt_wait", 0, 10);
        chk("t3_gnt", gnt, 4'b0100);
        req = '0;
        wait_for("t3_done_wait", 1, 100);
        chk("t3_done", done, 4'b0100);
        chk("t3_rx", rx_dat, 9'h155);
        repeat (20) @(negedge clk);
        chk("t3_done_pulses", done_cnt, 1);

        // tx_dat change during WAIT_HI
        set_tx(1, 9'h0C3);
        req = 4'b0010;
        wait_for("t5_gnt_wait", 0, 10);
        chk("t5_gnt", gnt, 4'b0010);
        req = '0;
        wait_for("t5_lo_wait", 2, 10);
        tick();
        set_tx(1, 9'h13C);
        wait_for("t5_done_wait", 1, 100);
        chk("t5_di", spi_di, 9'h0C3);
        chk("t5_rx", rx_dat, 9'h0C3);
        wait_for("t5_idle", 5, 10);
        chk("t5_di_hold", spi_di, 9'h0C3);

        // clr in WAIT_HI
        done_cnt = 0;
        req = 4'b1000;
        wait_for("t4_gnt_wait", 0, 10);
        chk("t4_gnt", gnt, 4'b1000);
        req = '0;
        wait_for("t4_lo_wait", 2, 10);
        tick();
        clr = 1'b1;
        @(negedge clk);
        chk("t4_clr_gnt", gnt, 0);
        chk("t4_clr_busy", busy, 0);
        chk("t4_clr_done", done, 0);
        chk("t4_clr_rx", rx_dat, 0);
        chk("t4_clr_di", spi_di, 0);
        tick(); clr = 1'b0;
        repeat (15) @(negedge clk);
        chk("t4_no_done", done_cnt, 0);
        req = 4'b1111;
        wait_for("t4_next_wait", 0, 10);
        chk("t4_next_gnt", gnt, 4'b0001);
        req = '0;
        wait_for("t4_done_wait", 1, 100);
        wait_for("t4_idle", 5, 10);

        // master never responds
        m_stuck = 1; done_cnt = 0;
        req = 4'b0001;
        wait_for("t6_st_wait", 3, 10);
        t_st = cyc;
        req = '0;
`ifdef SPI_ARB_TIMEOUT_EN
        wait_for("t6_err_wait", 4, 60);
        chk("t6_err_delay", 32'(cyc - t_st), TMO + 1);
        chk("t6_done", done, 0);
        @(negedge clk);
        chk("t6_busy_fall", busy, 0);
        chk("t6_no_done", done_cnt, 0);
`else
        repeat (40) @(negedge clk);
        chk("t6_busy_held", busy, 1);
        chk("t6_no_err", err, 0);
        tick(); clr = 1'b1; tick(); clr = 1'b0;
`endif
        m_stuck = 0;
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
